// File: rtl/sram_1rw_arbiter.sv
// Round-robin read/write arbiter in front of a single-port SRAM, with a 2-entry read-response FIFO.
// Define SRAM_ARB_ZERO_INIT_EN to zero-fill the SRAM after reset before any request is accepted.
module sram_1rw_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 52,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("DEPTH must equal 2**ADDR_W");
  end

  logic              run;
  logic              sweeping;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef SRAM_ARB_ZERO_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      sweep_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
    end
  end

  // Outputs are gated by rst so the SRAM stays idle while reset is held.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    sweeping     = 1'b0;
    run          = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          sweeping     = 1'b1;
          sweep_addr_d = sweep_addr_q + ADDR_W'(1);
          if (sweep_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
        end
        ST_RUN:  run = 1'b1;
        default: ;
      endcase
    end
  end

  assign sweep_addr = sweep_addr_q;
`else
  assign run        = ~rst;
  assign sweeping   = 1'b0;
  assign sweep_addr = '0;
`endif

  assign init_done = run;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_wr_ptr, fifo_rd_ptr;
  logic [1:0]        fifo_count;
  logic              inflight_q;
  logic              last_grant_wr_q;
  logic              push, deq;
  logic [2:0]        occupancy;
  logic              rd_can, rd_cand, wr_cand;
  logic              grant_rd, grant_wr;

  assign push          = inflight_q;
  assign rd_resp_valid = (fifo_count != 2'd0);
  assign rd_resp_data  = fifo_mem[fifo_rd_ptr];
  assign deq           = rd_resp_valid & rd_resp_ready;

  // Counting the in-flight read as occupied is what keeps the FIFO from overflowing.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, deq};
  assign rd_can    = (occupancy < 3'd2);
  assign rd_cand   = run & rd_req_valid & rd_can;
  assign wr_cand   = run & wr_req_valid;
  assign grant_rd  = rd_cand & (~wr_cand | last_grant_wr_q);
  assign grant_wr  = wr_cand & (~rd_cand | ~last_grant_wr_q);

  assign rd_req_ready = grant_rd;
  assign wr_req_ready = grant_wr;

  always_comb begin
    sram_en         = 1'b0;
    sram_write      = 1'b0;
    sram_addr       = '0;
    sram_write_data = '0;
    if (sweeping) begin
      sram_en    = 1'b1;
      sram_write = 1'b1;
      sram_addr  = sweep_addr;
    end else if (grant_wr) begin
      sram_en         = 1'b1;
      sram_write      = 1'b1;
      sram_addr       = wr_req_addr;
      sram_write_data = wr_req_data;
    end else if (grant_rd) begin
      sram_en   = 1'b1;
      sram_addr = rd_req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_ptr     <= 1'b0;
      fifo_rd_ptr     <= 1'b0;
      fifo_count      <= 2'd0;
      inflight_q      <= 1'b0;
      last_grant_wr_q <= 1'b1;
    end else begin
      inflight_q <= grant_rd;
      if (grant_rd | grant_wr) last_grant_wr_q <= grant_wr;
      if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
      if (deq)  fifo_rd_ptr <= ~fifo_rd_ptr;
      case ({push, deq})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[fifo_wr_ptr] <= sram_read_data;
  end

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Self-checking bench for sram_1rw_arbiter with a behavioural 1RW SRAM model.
// Sweep checks apply when SRAM_ARB_ZERO_INIT_EN is defined, matching the DUT build.
module tb_sram_1rw_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 52;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_req_valid = 1'b0, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr = '0;
  logic              rd_resp_valid, rd_resp_ready = 1'b0;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid = 1'b0, wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr = '0;
  logic [DATA_W-1:0] wr_req_data = '0;
  logic              init_done, sram_en, sram_write;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_write_data;
  logic [DATA_W-1:0] sram_read_data = '0;

  always #5 clk = ~clk;

  sram_1rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .init_done(init_done),
    .sram_en(sram_en), .sram_write(sram_write), .sram_addr(sram_addr),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
  );

  function automatic logic [DATA_W-1:0] pattern(input int unsigned i);
    return 52'hBAD0000000000 | DATA_W'(i);
  endfunction

  function automatic logic [DATA_W-1:0] t4data(input int unsigned k);
    return 52'hC0FFEE0000000 + DATA_W'(k);
  endfunction

  // SRAM model: seeded with a nonzero pattern; Q is junk except after a read access.
  logic [DATA_W-1:0] sram_mem [DEPTH];
  logic              mem_seeded = 1'b0;
  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int unsigned i = 0; i < DEPTH; i++) sram_mem[i] <= pattern(i);
      mem_seeded <= 1'b1;
    end else if (sram_en && sram_write) begin
      sram_mem[sram_addr] <= sram_write_data;
    end
    if (sram_en && !sram_write) sram_read_data <= sram_mem[sram_addr];
    else                        sram_read_data <= DATA_W'({$urandom(), $urandom()});
  end

  logic [DATA_W-1:0] shadow [DEPTH];
  logic [DATA_W-1:0] sb [$];
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned cyc = 0, n_pop = 0, first_resp = 0, last_resp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rv, input logic [ADDR_W-1:0] ra, input logic wv,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd, input logic rr);
    @(negedge clk);
    rst = 1'b0;
    rd_req_valid = rv; rd_req_addr = ra;
    wr_req_valid = wv; wr_req_addr = wa; wr_req_data = wd;
    rd_resp_ready = rr;
    #1;
  endtask

  task automatic commit();
    logic [DATA_W-1:0] e;
    if (rd_resp_valid && rd_resp_ready) begin
      check("resp_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("resp_data", 64'(rd_resp_data), 64'(e));
        if (n_pop == 0) first_resp = cyc;
        last_resp = cyc;
        n_pop++;
      end
    end
    if (rd_req_valid && rd_req_ready) sb.push_back(shadow[rd_req_addr]);
    if (wr_req_valid && wr_req_ready) shadow[wr_req_addr] = wr_req_data;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset(input logic rv, input logic wv, input logic chk);
    @(negedge clk);
    rst = 1'b1;
    rd_req_valid = rv; wr_req_valid = wv; rd_resp_ready = 1'b0;
    #1;
    if (chk)
      check("reset_outputs",
            64'({rd_req_ready, wr_req_ready, rd_resp_valid, sram_en, sram_write, init_done}), 64'd0);
    @(posedge clk);
    cyc++;
    sb.delete();
  endtask

  task automatic after_reset(input logic rv, input logic wv, input int unsigned nchk);
`ifdef SRAM_ARB_ZERO_INIT_EN
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive(rv, '0, wv, '0, '0, 1'b1);
      if (i < nchk)
        check($sformatf("sweep%0d", i),
              {sram_en, sram_write, sram_addr, sram_write_data,
               init_done, rd_req_ready, wr_req_ready, rd_resp_valid},
              {2'b11, ADDR_W'(i), {DATA_W{1'b0}}, 4'b0000});
      commit();
    end
    for (int unsigned a = 0; a < DEPTH; a++) shadow[a] = '0;
`endif
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    check("init_done", 64'({init_done, rd_resp_valid}), 64'b10);
    commit();
  endtask

  task automatic flush();
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
      if (sb.size() == 0 && !rd_resp_valid) break;
      commit();
    end
    check("flush_empty", 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic              rv, wv, exp_r, exp_w;
    logic [ADDR_W-1:0] ra, wa;
    logic [DATA_W-1:0] wd;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic wv, input logic er, input logic ew,
                              input int unsigned i);
    vec_t v;
    v.rv = rv; v.wv = wv; v.exp_r = er; v.exp_w = ew;
    v.ra = ADDR_W'(i);
    v.wa = ADDR_W'(i + 16);
    v.wd = 52'h5A5A000000000 + DATA_W'(i * 17 + 3);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t              vecs [14];
    vec_t              v;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] exp9;
    int unsigned       nacc;

    for (int unsigned i = 0; i < 8; i++) vecs[i] = mk(1'b1, 1'b1, i % 2 == 0, i % 2 == 1, i);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 8);
    vecs[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 9);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 10);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 11);
    vecs[12] = mk(1'b1, 1'b1, 1'b1, 1'b0, 12);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 1'b1, 13);
    for (int unsigned i = 0; i < DEPTH; i++) shadow[i] = pattern(i);
`ifdef SRAM_ARB_ZERO_INIT_EN
    exp9 = '0;
`else
    exp9 = pattern(9);
`endif

    // Reset state and zero-fill sweep with both requesters knocking
    do_reset(1'b1, 1'b1, 1'b1);
    after_reset(1'b1, 1'b1, DEPTH);

    // Write then read back, two-cycle response latency
    drive(1'b0, '0, 1'b1, 6'd5, 52'hABCDE, 1'b1);
    check("t2_wr_ready", 64'(wr_req_ready), 64'd1);
    commit();
    drive(1'b1, 6'd5, 1'b0, '0, '0, 1'b1);
    check("t2_rd_ready", 64'(rd_req_ready), 64'd1);
    commit();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    check("t2_lat_t1", 64'(rd_resp_valid), 64'd0);
    commit();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    check("t2_lat_t2", 64'({rd_resp_valid, rd_resp_data}), 64'({1'b1, 52'hABCDE}));
    commit();
    drive(1'b1, 6'd9, 1'b0, '0, '0, 1'b1);
    commit();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    commit();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    check("t2_addr9", 64'({rd_resp_valid, rd_resp_data}), 64'({1'b1, exp9}));
    commit();

    // Arbitration table right after reset
    do_reset(1'b0, 1'b0, 1'b0);
    after_reset(1'b0, 1'b0, 0);
    for (int unsigned i = 0; i < 14; i++) begin
      v = vecs[i];
      drive(v.rv, v.ra, v.wv, v.wa, v.wd, 1'b1);
      ea = v.exp_r ? v.ra : (v.exp_w ? v.wa : '0);
      check($sformatf("t3_vec%0d", i),
            64'({rd_req_ready, wr_req_ready, sram_en, sram_write, sram_addr, sram_write_data}),
            64'({v.exp_r, v.exp_w, v.exp_r | v.exp_w, v.exp_w, ea,
                 v.exp_w ? v.wd : {DATA_W{1'b0}}}));
      commit();
    end
    flush();

    // Stalled consumer: only two reads fit, head data held stable
    for (int unsigned k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1, ADDR_W'(20 + k), t4data(k), 1'b1);
      check("t4_wr_ready", 64'(wr_req_ready), 64'd1);
      commit();
    end
    for (int unsigned k = 0; k < 4; k++) begin
      nacc = (k < 2) ? k : 2;
      drive(1'b1, ADDR_W'(20 + nacc), 1'b0, '0, '0, 1'b0);
      check($sformatf("t4_rd_ready%0d", k), 64'(rd_req_ready), 64'(k < 2));
      commit();
    end
    for (int unsigned k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      check("t4_hold", 64'({rd_resp_valid, rd_resp_data}), 64'({1'b1, t4data(0)}));
      commit();
    end
    n_pop = 0;
    flush();
    check("t4_pops", 64'(n_pop), 64'd2);

    // Back-to-back reads with a draining consumer
    n_pop = 0;
    nacc = 0;
    for (int unsigned k = 0; k < 16; k++) begin
      drive(1'b1, ADDR_W'(16 + k), 1'b0, '0, '0, 1'b1);
      if (rd_req_ready) nacc++;
      commit();
    end
    flush();
    check("t5_accepts", 64'(nacc), 64'd16);
    check("t5_pops", 64'(n_pop), 64'd16);
    check("t5_spacing", 64'(last_resp - first_resp), 64'd15);

    // Reset with a read in flight and data waiting in the FIFO
    drive(1'b1, 6'd30, 1'b0, '0, '0, 1'b0);
    check("t6_rd_ready0", 64'(rd_req_ready), 64'd1);
    commit();
    drive(1'b1, 6'd31, 1'b0, '0, '0, 1'b0);
    check("t6_rd_ready1", 64'(rd_req_ready), 64'd1);
    commit();
    do_reset(1'b0, 1'b0, 1'b0);
    after_reset(1'b0, 1'b0, 4);
    for (int unsigned k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
      check("t6_no_stale", 64'(rd_resp_valid), 64'd0);
      commit();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
